// File: rtl/alarm_controller_pkg.sv
// Shared types and constants for the countdown alarm controller.
// The optional feature macro ALARM_CONTROLLER_DEBOUNCE_EN is consumed by button_conditioner.
package alarm_controller_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned LED_W   = 9;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT      = 4'd9;
    localparam logic [DIGIT_W-1:0] SSD_ALARM_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_ALARM  = 2'd2,
        ST_SNOOZE = 2'd3
    } state_e;

    typedef struct packed {
        logic start_stop;
        logic snooze;
        logic set;
    } btn_evt_t;

    // LED bar with bit i lit when i < n
    function automatic logic [LED_W-1:0] thermometer(input logic [DIGIT_W-1:0] n);
        logic [LED_W-1:0] t;
        t = '0;
        for (int i = 0; i < int'(LED_W); i++) begin
            t[i] = (DIGIT_W'(i) < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/alarm_controller_button_conditioner.sv
// Active-low button: 2-FF synchronizer, optional debounce (ALARM_CONTROLLER_DEBOUNCE_EN),
// and a one-cycle press pulse on the accepted high-to-low transition.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_o
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef ALARM_CONTROLLER_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // Accept a new level only after it differs from the current one for DEBOUNCE_CYCLES cycles
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end
`else
    logic press_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            press_q <= 1'b0;
        end else begin
            press_q <= sync2_q & ~sync1_q;
        end
    end
`endif

    assign press_o = press_q;

endmodule

// File: rtl/alarm_controller.sv
// Single-digit countdown alarm: set digit, run, fire, snooze, cancel.
// Build with ALARM_CONTROLLER_DEBOUNCE_EN to enable button debouncing.
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned SNOOZE_UNITS    = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_stop_button,
    input  logic             set_button,
    input  logic             snooze_button,
    output logic [DIGIT_W-1:0] ssd_led_out,
    output logic [LED_W-1:0]   led_out
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DIGIT_W-1:0] SNOOZE_DIGIT = DIGIT_W'(SNOOZE_UNITS);

    if (SNOOZE_UNITS < 1 || SNOOZE_UNITS > 9) begin : g_bad_snooze
        $error("SNOOZE_UNITS must be in 1..9");
    end
    if (TICK_CYCLES < 1) begin : g_bad_tick
        $error("TICK_CYCLES must be at least 1");
    end

    btn_evt_t evt;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (start_stop_button),
        .press_o (evt.start_stop)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_snooze (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (snooze_button),
        .press_o (evt.snooze)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_set (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (set_button),
        .press_o (evt.set)
    );

    state_e              state_q, state_d;
    logic [DIGIT_W-1:0]  set_val_q, set_val_d;
    logic [DIGIT_W-1:0]  remaining_q, remaining_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                blink_q, blink_d;
    logic [DIGIT_W-1:0]  ssd_q, ssd_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic                tick;

    assign tick = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            set_val_q   <= '0;
            remaining_q <= '0;
            tick_cnt_q  <= '0;
            blink_q     <= 1'b1;
            ssd_q       <= '0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            set_val_q   <= set_val_d;
            remaining_q <= remaining_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_q     <= blink_d;
            ssd_q       <= ssd_d;
            led_q       <= led_d;
        end
    end

    // Next state; start_stop beats snooze beats set within each state
    always_comb begin
        state_d     = state_q;
        set_val_d   = set_val_q;
        remaining_d = remaining_q;
        blink_d     = blink_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (evt.start_stop) begin
                    if (set_val_q != '0) begin
                        state_d     = ST_RUN;
                        remaining_d = set_val_q;
                    end
                end else if (evt.set) begin
                    set_val_d = (set_val_q == MAX_DIGIT) ? '0 : set_val_q + 1'b1;
                end
            end
            ST_RUN, ST_SNOOZE: begin
                if (evt.start_stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (remaining_q <= 4'd1) begin
                        state_d     = ST_ALARM;
                        remaining_d = '0;
                        tick_cnt_d  = '0;
                        blink_d     = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            ST_ALARM: begin
                if (evt.start_stop) begin
                    state_d = ST_IDLE;
                end else if (evt.snooze) begin
                    state_d     = ST_SNOOZE;
                    remaining_d = SNOOZE_DIGIT;
                    tick_cnt_d  = '0;
                end else if (tick) begin
                    blink_d = ~blink_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display/LED registers follow the current state one cycle later
    always_comb begin
        ssd_d = set_val_q;
        led_d = '0;
        case (state_q)
            ST_RUN, ST_SNOOZE: begin
                ssd_d = remaining_q;
                led_d = thermometer(remaining_q);
            end
            ST_ALARM: begin
                ssd_d = SSD_ALARM_CODE;
                led_d = {LED_W{blink_q}};
            end
            default: begin
                ssd_d = set_val_q;
                led_d = '0;
            end
        endcase
    end

    assign ssd_led_out = ssd_q;
    assign led_out     = led_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller with a digit/mode reference model.
module tb_alarm_controller;

    localparam int unsigned TICK = 100;
    localparam int unsigned DEB  = 4;
    localparam int unsigned SNZ  = 2;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       ss_n  = 1'b1;
    logic       set_n = 1'b1;
    logic       snz_n = 1'b1;
    logic [3:0] ssd;
    logic [8:0] led;

    int total = 0;
    int bad   = 0;
    int m_set = 0;

    alarm_controller #(
        .TICK_CYCLES     (TICK),
        .DEBOUNCE_CYCLES (DEB),
        .SNOOZE_UNITS    (SNZ)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .start_stop_button (ss_n),
        .set_button        (set_n),
        .snooze_button     (snz_n),
        .ssd_led_out       (ssd),
        .led_out           (led)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [8:0] bar(input int n);
        return 9'((1 << n) - 1);
    endfunction

    task automatic drive(input int b, input logic v);
        case (b)
            0:       ss_n  = v;
            1:       set_n = v;
            default: snz_n = v;
        endcase
    endtask

    task automatic press(input int b);
        int hold;
        int gap;
        hold = 10 + int'($urandom_range(0, 5));
        gap  = 12 + int'($urandom_range(0, 5));
        drive(b, 1'b0);
        cyc(hold);
        drive(b, 1'b1);
        cyc(gap);
    endtask

    task automatic wait_out(input logic [3:0] es, input logic [8:0] el, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (ssd === es && led === el) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        m_set = 0;
        cyc(1);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc(1);
        total++; if (ssd !== 4'h0) begin bad++; $display("FAIL reset_ssd got=%0h want=0", ssd); end
        total++; if (led !== 9'h0) begin bad++; $display("FAIL reset_led got=%0h want=0", led); end
        RST = 1'b0;
        m_set = 0;
        cyc(2);
        total++; if (ssd !== 4'h0) begin bad++; $display("FAIL idle_ssd got=%0h want=0", ssd); end
        total++; if (led !== 9'h0) begin bad++; $display("FAIL idle_led got=%0h want=0", led); end
    endtask

    task automatic test_set_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            press(1);
            m_set = (m_set + 1) % 10;
            total++; if (ssd !== 4'(m_set)) begin bad++; $display("FAIL set3 ssd got=%0h want=%0h", ssd, m_set); end
        end
        do_reset();
        for (int i = 0; i < 11; i++) begin
            press(1);
            m_set = (m_set + 1) % 10;
            total++; if (ssd !== 4'(m_set)) begin bad++; $display("FAIL set11 ssd got=%0h want=%0h", ssd, m_set); end
        end
        total++; if (led !== 9'h0) begin bad++; $display("FAIL set_led got=%0h want=0", led); end
    endtask

    task automatic test_start_zero();
        do_reset();
        press(0);
        total++; if (ssd !== 4'h0 || led !== 9'h0) begin bad++; $display("FAIL start_zero got=%0h/%0h want=0/0", ssd, led); end
        cyc(2 * TICK);
        total++; if (ssd !== 4'h0 || led !== 9'h0) begin bad++; $display("FAIL start_zero_hold got=%0h/%0h want=0/0", ssd, led); end
    endtask

    task automatic test_countdown(input int n);
        bit ok;
        do_reset();
        for (int i = 0; i < n; i++) press(1);
        m_set = n;
        total++; if (ssd !== 4'(n)) begin bad++; $display("FAIL cd_set got=%0h want=%0h", ssd, n); end
        ss_n = 1'b0;
        wait_out(4'(n), bar(n), 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL cd_start got=%0h/%0h want=%0h/%0h", ssd, led, n, bar(n)); end
        for (int k = 1; k <= n; k++) begin
            if (k == 1) begin
                cyc(10);
                ss_n = 1'b1;
                cyc(int'(TICK) - 11);
            end else begin
                cyc(int'(TICK) - 1);
            end
            total++; if (ssd !== 4'(n - k + 1)) begin bad++; $display("FAIL cd_before got=%0h want=%0h", ssd, n - k + 1); end
            cyc(1);
            if (k < n) begin
                total++; if (ssd !== 4'(n - k) || led !== bar(n - k)) begin bad++; $display("FAIL cd_step got=%0h/%0h want=%0h/%0h", ssd, led, n - k, bar(n - k)); end
            end else begin
                total++; if (ssd !== 4'hF || led !== 9'h1FF) begin bad++; $display("FAIL cd_alarm got=%0h/%0h want=f/1ff", ssd, led); end
            end
        end
        cyc(int'(TICK) - 1);
        total++; if (led !== 9'h1FF) begin bad++; $display("FAIL blink_on got=%0h want=1ff", led); end
        cyc(1);
        total++; if (ssd !== 4'hF || led !== 9'h000) begin bad++; $display("FAIL blink_off got=%0h/%0h want=f/0", ssd, led); end
        cyc(int'(TICK));
        total++; if (ssd !== 4'hF || led !== 9'h1FF) begin bad++; $display("FAIL blink_on2 got=%0h/%0h want=f/1ff", ssd, led); end
    endtask

    task automatic test_snooze();
        bit ok;
        snz_n = 1'b0;
        wait_out(4'(SNZ), bar(SNZ), 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL snooze_enter got=%0h/%0h want=%0h/%0h", ssd, led, SNZ, bar(SNZ)); end
        cyc(10);
        snz_n = 1'b1;
        cyc(int'(TICK) - 11);
        total++; if (ssd !== 4'(SNZ)) begin bad++; $display("FAIL snooze_before got=%0h want=%0h", ssd, SNZ); end
        cyc(1);
        total++; if (ssd !== 4'(SNZ - 1) || led !== bar(SNZ - 1)) begin bad++; $display("FAIL snooze_step got=%0h/%0h want=%0h/%0h", ssd, led, SNZ - 1, bar(SNZ - 1)); end
        cyc(int'(TICK));
        total++; if (ssd !== 4'hF || led !== 9'h1FF) begin bad++; $display("FAIL snooze_realarm got=%0h/%0h want=f/1ff", ssd, led); end
    endtask

    task automatic test_cancel();
        bit ok;
        ss_n = 1'b0;
        wait_out(4'(m_set), 9'h0, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL cancel_alarm got=%0h/%0h want=%0h/0", ssd, led, m_set); end
        cyc(10);
        ss_n = 1'b1;
        cyc(15);
        ss_n = 1'b0;
        wait_out(4'(m_set), bar(m_set), 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL cancel_restart got=%0h/%0h want=%0h/%0h", ssd, led, m_set, bar(m_set)); end
        cyc(10);
        ss_n = 1'b1;
        cyc(15);
        press(0);
        total++; if (ssd !== 4'(m_set) || led !== 9'h0) begin bad++; $display("FAIL cancel_run got=%0h/%0h want=%0h/0", ssd, led, m_set); end
        cyc(int'(TICK) * (m_set + 1));
        total++; if (ssd !== 4'(m_set) || led !== 9'h0) begin bad++; $display("FAIL cancel_stay got=%0h/%0h want=%0h/0", ssd, led, m_set); end
    endtask

    task automatic test_priority();
        bit ok;
        ss_n = 1'b0;
        wait_out(4'(m_set), bar(m_set), 40, ok);
        ss_n = 1'b1;
        total++; if (!ok) begin bad++; $display("FAIL prio_start got=%0h/%0h want=%0h/%0h", ssd, led, m_set, bar(m_set)); end
        wait_out(4'hF, 9'h1FF, m_set * int'(TICK) + 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL prio_alarm got=%0h/%0h want=f/1ff", ssd, led); end
        cyc(int'($urandom_range(3, 30)));
        ss_n  = 1'b0;
        snz_n = 1'b0;
        cyc(15);
        ss_n  = 1'b1;
        snz_n = 1'b1;
        cyc(15);
        total++; if (ssd !== 4'(m_set) || led !== 9'h0) begin bad++; $display("FAIL prio_idle got=%0h/%0h want=%0h/0", ssd, led, m_set); end
        cyc(3 * int'(TICK));
        total++; if (ssd !== 4'(m_set) || led !== 9'h0) begin bad++; $display("FAIL prio_stay got=%0h/%0h want=%0h/0", ssd, led, m_set); end
    endtask

    task automatic test_glitch_hold();
`ifdef ALARM_CONTROLLER_DEBOUNCE_EN
        set_n = 1'b0;
        cyc(2);
        set_n = 1'b1;
        cyc(20);
        total++; if (ssd !== 4'(m_set)) begin bad++; $display("FAIL glitch got=%0h want=%0h", ssd, m_set); end
`endif
        set_n = 1'b0;
        cyc(60);
        m_set = (m_set + 1) % 10;
        total++; if (ssd !== 4'(m_set)) begin bad++; $display("FAIL hold got=%0h want=%0h", ssd, m_set); end
        set_n = 1'b1;
        cyc(20);
        total++; if (ssd !== 4'(m_set)) begin bad++; $display("FAIL hold_release got=%0h want=%0h", ssd, m_set); end
    endtask

    task automatic test_random_idle();
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                press(2);
            end else begin
                press(1);
                m_set = (m_set + 1) % 10;
            end
            total++; if (ssd !== 4'(m_set) || led !== 9'h0) begin bad++; $display("FAIL rand_idle got=%0h/%0h want=%0h/0", ssd, led, m_set); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        if (m_set == 0) begin
            press(1);
            m_set = 1;
        end
        ss_n = 1'b0;
        wait_out(4'(m_set), bar(m_set), 40, ok);
        ss_n = 1'b1;
        total++; if (!ok) begin bad++; $display("FAIL mid_start got=%0h/%0h want=%0h/%0h", ssd, led, m_set, bar(m_set)); end
        cyc(int'($urandom_range(5, 80)));
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        m_set = 0;
        total++; if (ssd !== 4'h0 || led !== 9'h0) begin bad++; $display("FAIL mid_reset got=%0h/%0h want=0/0", ssd, led); end
        cyc(2 * int'(TICK));
        total++; if (ssd !== 4'h0 || led !== 9'h0) begin bad++; $display("FAIL mid_reset_stay got=%0h/%0h want=0/0", ssd, led); end
    endtask

    initial begin
        cyc(2);
        test_reset();
        test_set_wrap();
        test_start_zero();
        test_countdown(3);
        test_snooze();
        test_cancel();
        test_priority();
        test_glitch_hold();
        test_countdown(int'($urandom_range(1, 9)));
        test_snooze();
        test_cancel();
        test_random_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Single-digit countdown alarm for a board with three active-low push buttons, one BCD seven-segment digit and a 9-LED bar. The user sets a duration of 0–9 time units, starts a countdown, then stops or snoozes the alarm when it fires. The block is board top-level control logic; it drives the SSD decoder input and the LEDs directly.

## Interface
- TICK_CYCLES, 100000: clock cycles per countdown unit (2 ms at 50 MHz).
- DEBOUNCE_CYCLES, 1000: cycles a button level must be stable before it is accepted.
- SNOOZE_UNITS, 5: countdown units reloaded on snooze, 1–9.
- CLK  input  1  system clock; the block uses one clock, all logic on its rising edge.
- RST  input  1  reset, synchronous, active-high.
- start_stop_button  input  1  active-low; a press starts the countdown or cancels it or the alarm.
- set_button  input  1  active-low; a press increments the set digit.
- snooze_button  input  1  active-low; a press snoozes a firing alarm.
- ssd_led_out  output  4  BCD digit to the SSD decoder; 4'hF while the alarm is firing.
- led_out  output  9  LED bar.

## Operation
- Each button is synchronized with 2 flip-flops, then debounced, then edge-detected. One press produces a one-cycle press event on the high-to-low transition of the accepted level.
- States: IDLE, RUN, ALARM, SNOOZE.
- IDLE:
  - set → set_val = (set_val==9) ? 0 : set_val+1.
  - start_stop with set_val≠0 → RUN, remaining = set_val. start_stop with set_val==0 is ignored.
  - snooze is ignored.
- RUN:
  - Each tick → remaining−1. When remaining reaches 0 → ALARM.
  - start_stop → IDLE.
  - set and snooze are ignored.
- ALARM:
  - snooze → SNOOZE, remaining = SNOOZE_UNITS.
  - start_stop → IDLE.
  - set is ignored.
- SNOOZE: countdown as in RUN, then → ALARM. start_stop → IDLE. set and snooze are ignored.
- set_val is retained across runs and stops.
- Simultaneous events: start_stop has priority over snooze, and snooze over set.
- Outputs:
  - IDLE: ssd = set_val, led = 0.
  - RUN/SNOOZE: ssd = remaining. led = thermometer, with led_out[i] = (i < remaining).
  - ALARM: ssd = 4'hF. led = all 9 bits blinking: all-on at entry, toggling every tick.
- Tick counter:
  - Cleared on entry to RUN, SNOOZE and ALARM.
  - A tick fires when the counter reaches TICK_CYCLES−1, then the counter wraps to 0.

## Timing
- Reset values: state IDLE, set_val 0, remaining 0, ssd_led_out 0, led_out 0, tick counter 0, blink phase on, button filters released.
- Reset mid-operation returns to IDLE on the next edge. Pending press events are discarded.
- Press latency: 2 sync cycles + DEBOUNCE_CYCLES to the event pulse, +1 cycle for the state/register update.
- Outputs are registered and change 1 cycle after the state change.
- First decrement occurs exactly TICK_CYCLES cycles after entering RUN or SNOOZE.
- Held button: a single event only. A new event requires release and re-press, each stable for DEBOUNCE_CYCLES.

## Configuration
- ALARM_CONTROLLER_DEBOUNCE_EN defined: the debounce counter is present as specified.
- Undefined: the debounce counter is removed. Events come from the synchronized level edge directly, with latency 2 sync cycles + 1, and DEBOUNCE_CYCLES is unused.

## Structure
- Package alarm_controller_pkg holds:
  - the state enum;
  - MAX_DIGIT = 9;
  - SSD_ALARM_CODE = 4'hF.
- Sub-module button_conditioner handles synchronization, optional debounce and the press-edge pulse. It is instantiated three times.

## Test plan
All scenarios use TICK_CYCLES=100, DEBOUNCE_CYCLES=4, SNOOZE_UNITS=2.
- Reset: assert RST 1 cycle with buttons high → ssd=0, led=0, state IDLE.
- Set wrap: 3 set presses → ssd=3. 11 presses from reset → ssd=1 (9→0 wrap).
- Countdown: set 3, press start → led=9'b000000111 and ssd=3. After 100 cycles ssd=2. At 300 cycles ssd=F and led blinks 9'h1FF/0 every 100 cycles.
- Snooze: press snooze in ALARM → ssd=2 and led=9'b11. After 200 cycles ssd=F again.
- Cancel: press start_stop in RUN or ALARM → IDLE, ssd=set_val, led=0. Press start with set_val=0 → stays IDLE.
- Priority/glitch: start and snooze pressed in the same cycle during ALARM → IDLE. A 2-cycle low glitch on set produces no increment (debounce enabled).
